// File: rtl/button_bounce_gen.sv
// Pushbutton emulator: drives an active-low line through press bounce, hold, release bounce.
// Optional HOLD contact-chatter glitch enabled by defining BUTTON_BOUNCE_GEN_GLITCH_EN.
module button_bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 120000,
  parameter int unsigned HOLD_CYCLES   = 600000,
  parameter int unsigned TOGGLE_BASE   = 240,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned GLITCH_CYCLES = 12
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic press_req,
  output logic ready,
  output logic btn_n,
  output logic pressed,
  output logic done
);

  localparam int unsigned WIN_MAX = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int WIN_W = $clog2(WIN_MAX + 1);
  localparam int TOG_W = $clog2(TOGGLE_BASE + 256);

  localparam logic [WIN_W-1:0] B_LAST = (BOUNCE_CYCLES > 0) ? WIN_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [WIN_W-1:0] H_LAST = WIN_W'(HOLD_CYCLES - 1);
  // Glitch bounds expressed on the down-counting HOLD counter of the following cycle.
  localparam logic [WIN_W-1:0] GL_HI = WIN_W'(HOLD_CYCLES - 1 - HOLD_CYCLES / 2);
  localparam logic [WIN_W-1:0] GL_LO = WIN_W'(HOLD_CYCLES - HOLD_CYCLES / 2 - GLITCH_CYCLES);

`ifdef BUTTON_BOUNCE_GEN_GLITCH_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PB,
    S_HOLD,
    S_RB,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               btn_n_q;
  logic               ready_q;
  logic               pressed_q;
  logic               done_q;
  logic [15:0]        lfsr_q;
  logic [WIN_W-1:0]   wcnt_q;
  logic [TOG_W-1:0]   tog_q;

  logic [15:0]        lfsr_d;
  logic [WIN_W-1:0]   wcnt_d;
  logic [TOG_W-1:0]   tog_load;
  logic [TOG_W-1:0]   tog_d;
  logic               tog_hit;
  logic               hold_lvl;

  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign wcnt_d   = wcnt_q - WIN_W'(1);
  assign tog_load = TOG_W'(TOGGLE_BASE) + TOG_W'(lfsr_q[7:0]);
  // The counter never rests at zero: reaching it is the same edge as the reload.
  assign tog_hit  = (tog_q == TOG_W'(1));
  assign tog_d    = tog_hit ? tog_load : (tog_q - TOG_W'(1));
  assign hold_lvl = GLITCH_EN && (wcnt_d >= GL_LO) && (wcnt_d <= GL_HI);

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state_q   <= S_IDLE;
      btn_n_q   <= 1'b1;
      ready_q   <= 1'b1;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      wcnt_q    <= '0;
      tog_q     <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (press_req) begin
            ready_q   <= 1'b0;
            pressed_q <= 1'b1;
            btn_n_q   <= 1'b0;
            if (BOUNCE_CYCLES == 0) begin
              state_q <= S_HOLD;
              wcnt_q  <= H_LAST;
            end else begin
              state_q <= S_PB;
              wcnt_q  <= B_LAST;
              tog_q   <= tog_load;
            end
          end
        end
        S_PB: begin
          if (wcnt_q == '0) begin
            state_q <= S_HOLD;
            wcnt_q  <= H_LAST;
            btn_n_q <= 1'b0;
          end else begin
            wcnt_q <= wcnt_d;
            tog_q  <= tog_d;
            if (tog_hit) btn_n_q <= ~btn_n_q;
          end
        end
        S_HOLD: begin
          if (wcnt_q == '0) begin
            pressed_q <= 1'b0;
            btn_n_q   <= 1'b1;
            if (BOUNCE_CYCLES == 0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RB;
              wcnt_q  <= B_LAST;
              tog_q   <= tog_load;
            end
          end else begin
            wcnt_q  <= wcnt_d;
            btn_n_q <= hold_lvl;
          end
        end
        S_RB: begin
          if (wcnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            btn_n_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_d;
            tog_q  <= tog_d;
            if (tog_hit) btn_n_q <= ~btn_n_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          btn_n_q   <= 1'b1;
          ready_q   <= 1'b1;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign btn_n   = btn_n_q;
  assign pressed = pressed_q;
  assign done    = done_q;

endmodule
